// File: rtl/dram_arb_ctrl_if.sv
// rtl/dram_arb_ctrl_if.sv - one client port of the dram arbiter
// Purpose: bundles one master's request/grant and read-return signals.
// Ports (per instance):
//   req, we, addr, wdata, be   client -> arbiter  request, direction, word address, write data, byte enables
//   gnt                        arbiter -> client  combinational grant (req & gnt = accepted this cycle)
//   rvalid, rdata              arbiter -> client  read data valid one cycle after an accepted read, read data
// Modports: master (client engine side), slave (arbiter side).
interface dram_arb_ctrl_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dram_arb_ctrl.sv
// rtl/dram_arb_ctrl.sv - two-master round-robin arbiter and zero-fill sequencer for a single-port dram
// Purpose: after reset optionally sweeps the whole RAM to zero, then shares the single RAM port
//          between two masters, one transaction per cycle, with per-master read return.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   m0, m1          client ports (dram_arb_ctrl_if.slave): req/we/addr/wdata/be in, gnt/rvalid/rdata out
//   ram_addr        word address to the dram
//   ram_wr_data     write data to the dram
//   ram_wr_en       write enable to the dram
//   ram_wr_byte_en  byte enables to the dram
//   ram_rd_data     read data from the dram (1-cycle latency, unregistered output)
//   init_done       high once the zero-fill sweep has finished
module dram_arb_ctrl #(
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dram_arb_ctrl_if.slave        m0,
    dram_arb_ctrl_if.slave        m1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  last_m1;   // 1: m1 was granted last, so m0 wins a tie
    logic                  m0_rv_q;
    logic                  m1_rv_q;

    logic                  in_run;
    logic                  sel_m1;
    logic                  grant_any;

    // Grants are suppressed while rst is high so nothing is accepted in the reset cycle.
    assign in_run    = (state == ST_RUN) && !rst;
    assign sel_m1    = m1.req && (!m0.req || !last_m1);
    assign grant_any = in_run && (m0.req || m1.req);

    assign m0.gnt = in_run && m0.req && !sel_m1;
    assign m1.gnt = in_run && sel_m1;

    // A read accepted just before reset must not report its data.
    assign m0.rvalid = m0_rv_q && !rst;
    assign m1.rvalid = m1_rv_q && !rst;
    assign m0.rdata  = ram_rd_data;
    assign m1.rdata  = ram_rd_data;

    always_comb begin
        ram_addr       = '0;
        ram_wr_data    = '0;
        ram_wr_en      = 1'b0;
        ram_wr_byte_en = '0;
        if (state == ST_INIT) begin
            ram_addr       = clr_cnt;
            ram_wr_en      = 1'b1;
            ram_wr_byte_en = '1;
        end else if (grant_any) begin
            if (sel_m1) begin
                ram_addr       = m1.addr;
                ram_wr_data    = m1.wdata;
                ram_wr_en      = m1.we;
                ram_wr_byte_en = m1.be;
            end else begin
                ram_addr       = m0.addr;
                ram_wr_data    = m0.wdata;
                ram_wr_en      = m0.we;
                ram_wr_byte_en = m0.be;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            init_done <= (CLEAR_ON_RESET == 0);
            clr_cnt   <= '0;
            last_m1   <= 1'b1;
            m0_rv_q   <= 1'b0;
            m1_rv_q   <= 1'b0;
        end else begin
            m0_rv_q <= m0.gnt && !m0.we;
            m1_rv_q <= m1.gnt && !m1.we;
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (grant_any) begin
                        last_m1 <= sel_m1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arb_ctrl.sv
// tb/tb_dram_arb_ctrl.sv - self-checking bench for dram_arb_ctrl with a behavioural dram
module tb_dram_arb_ctrl;
    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) m0_if ();
    dram_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) m1_if ();

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_wr_en;
    logic [BW-1:0] ram_wr_byte_en;
    logic [DW-1:0] ram_rd_data;
    logic          init_done;

    dram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .CLEAR_ON_RESET(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0             (m0_if.slave),
        .m1             (m1_if.slave),
        .ram_addr       (ram_addr),
        .ram_wr_data    (ram_wr_data),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_byte_en (ram_wr_byte_en),
        .ram_rd_data    (ram_rd_data),
        .init_done      (init_done)
    );

    // Behavioural single-port dram: byte-enable writes, 1-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    logic          preload_req = 1'b1;
    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEADBEEF;
        end else if (ram_wr_en) begin
            for (int b = 0; b < BW; b++)
                if (ram_wr_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
        end
        ram_rd_data <= mem[ram_addr];
    end

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int cyc      = 0;
    int rv0_cnt  = 0;
    int rv1_cnt  = 0;
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expected word whenever a master reports read data.
    always @(negedge clk) begin
        if (m0_if.rvalid === 1'b1 && m1_if.rvalid === 1'b1) check("rvalid_both", 32'd1, 32'd0);
        if (m0_if.rvalid === 1'b1) begin
            rv0_cnt++;
            if (exp_q0.size() == 0) check("m0_unexpected_rvalid", 32'd1, 32'd0);
            else check("m0_rdata", m0_if.rdata, exp_q0.pop_front());
        end
        if (m1_if.rvalid === 1'b1) begin
            rv1_cnt++;
            if (exp_q1.size() == 0) check("m1_unexpected_rvalid", 32'd1, 32'd0);
            else check("m1_rdata", m1_if.rdata, exp_q1.pop_front());
        end
    end

    task automatic set_m(input int m, input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
        if (m == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d; m0_if.be = be;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d; m1_if.be = be;
        end
    endtask

    function automatic logic gnt_of(input int m);
        return (m == 0) ? m0_if.gnt : m1_if.gnt;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic xfer(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, input logic [DW-1:0] exp);
        int n = 0;
        set_m(m, 1'b1, we, a, d, be);
        @(negedge clk);
        while (gnt_of(m) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (gnt_of(m) !== 1'b1) check("gnt_timeout", 32'd0, 32'd1);
        else if (!we) begin
            if (m == 0) exp_q0.push_back(exp);
            else exp_q1.push_back(exp);
        end
        @(posedge clk);
        #1;
        set_m(m, 1'b0, 1'b0, '0, '0, '0);
    endtask

    int n_edges;
    int sweep_wr;
    int gnt_bad;
    int t0;
    int r0;
    int r1;
    int i0;
    int i1;
    logic exp_g0;

    initial begin
        set_m(0, 1'b1, 1'b0, 15'h0010, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        preload_req = 1'b0;
        @(negedge clk);
        check("gnt_during_rst", {31'd0, m0_if.gnt}, 32'd0);
        @(posedge clk); #1;
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_rvalid", {30'd0, m0_if.rvalid, m1_if.rvalid}, 32'd0);
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b0;

        // Reset in the middle of the sweep restarts it at word 0.
        repeat (1000) @(posedge clk);
        #1;
        check("sweep_addr_1000", {17'd0, ram_addr}, 32'd1000);
        check("sweep_wr_en", {31'd0, ram_wr_en}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("sweep_restart_addr", {17'd0, ram_addr}, 32'd0);
        check("sweep_restart_done", {31'd0, init_done}, 32'd0);

        // Full sweep with a write request held throughout INIT.
        set_m(0, 1'b1, 1'b1, 15'h0100, 32'hCAFEF00D, 4'hF);
        n_edges = 0; sweep_wr = 0; gnt_bad = 0;
        while (init_done !== 1'b1 && n_edges < 40000) begin
            @(negedge clk);
            if (ram_wr_en === 1'b1 && ram_wr_byte_en === 4'hF && ram_wr_data === 32'd0 &&
                ram_addr === sweep_wr[AW-1:0]) sweep_wr++;
            if (m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0) gnt_bad++;
            @(posedge clk); #1;
            n_edges++;
        end
        check("sweep_cycles", n_edges, 32'd32768);
        check("sweep_zero_writes", sweep_wr, 32'd32768);
        check("gnt_in_init", gnt_bad, 32'd0);
        check("first_run_gnt", {31'd0, m0_if.gnt}, 32'd1);
        check("first_run_wr_en", {31'd0, ram_wr_en}, 32'd1);
        @(posedge clk); #1;
        set_m(0, 1'b0, 1'b0, '0, '0, '0);

        // Preloaded words now read as zero; held write landed exactly once.
        xfer(0, 1'b0, 15'h0000, '0, '0, 32'h0);
        xfer(0, 1'b0, 15'h4000, '0, '0, 32'h0);
        xfer(0, 1'b0, 15'h7FFE, '0, '0, 32'h0);
        xfer(1, 1'b0, 15'h0100, '0, '0, 32'hCAFEF00D);

        // Back-to-back m0 reads of addresses 0..15.
        for (int i = 0; i < 16; i++) xfer(0, 1'b1, AW'(i), 32'h5A000000 + DW'(i), 4'hF, '0);
        repeat (2) @(posedge clk);
        #1;
        r0 = rv0_cnt; r1 = rv1_cnt; t0 = cyc;
        for (int i = 0; i < 16; i++) xfer(0, 1'b0, AW'(i), '0, '0, 32'h5A000000 + DW'(i));
        check("b2b_read_cycles", cyc - t0, 32'd16);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_m0_rvalid_cnt", rv0_cnt - r0, 32'd16);
        check("b2b_m1_rvalid_cnt", rv1_cnt - r1, 32'd0);

        // Byte-enable write, read-after-write, and be=0 write.
        xfer(1, 1'b1, 15'h7FFF, 32'h11223344, 4'b0101, '0);
        xfer(1, 1'b0, 15'h7FFF, '0, '0, 32'h00220044);
        xfer(1, 1'b1, 15'h7FFF, 32'hFFFFFFFF, 4'b0000, '0);
        xfer(1, 1'b0, 15'h7FFF, '0, '0, 32'h00220044);

        // Reset right after an accepted read suppresses its rvalid.
        set_m(0, 1'b1, 1'b0, 15'h0003, '0, '0);
        @(negedge clk);
        check("pre_rst_read_gnt", {31'd0, m0_if.gnt}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        set_m(0, 1'b1, 1'b1, 15'h0003, 32'h0, 4'hF);
        @(negedge clk);
        check("rst_suppress_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
        check("rst_run_gnt", {31'd0, m0_if.gnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        check("rst2_init_done", {31'd0, init_done}, 32'd0);
        n_edges = 0;
        while (init_done !== 1'b1 && n_edges < 40000) begin
            @(posedge clk); #1;
            n_edges++;
        end
        check("sweep2_cycles", n_edges, 32'd32768);

        // Both masters write continuously: strict alternation, m0 first.
        i0 = 0; i1 = 0;
        for (int k = 0; k < 8; k++) begin
            set_m(0, 1'b1, 1'b1, AW'(32'h200 + i0), 32'h20000000 + DW'(i0), 4'hF);
            set_m(1, 1'b1, 1'b1, AW'(32'h300 + i1), 32'h30000000 + DW'(i1), 4'hF);
            exp_g0 = (k % 2 == 0);
            @(negedge clk);
            check("rr_m0_gnt", {31'd0, m0_if.gnt}, {31'd0, exp_g0});
            check("rr_m1_gnt", {31'd0, m1_if.gnt}, {31'd0, !exp_g0});
            check("rr_wr_en", {31'd0, ram_wr_en}, 32'd1);
            check("rr_addr", {17'd0, ram_addr}, exp_g0 ? 32'h200 + i0 : 32'h300 + i1);
            @(posedge clk); #1;
            if (exp_g0) i0++;
            else i1++;
        end
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b0, AW'(32'h200 + i), '0, '0, 32'h20000000 + DW'(i));
            xfer(1, 1'b0, AW'(32'h300 + i), '0, '0, 32'h30000000 + DW'(i));
        end
        xfer(0, 1'b0, 15'h0204, '0, '0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("q0_drained", exp_q0.size(), 32'd0);
        check("q1_drained", exp_q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
